// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {instr, pc} between imem and decode, head read combinationally.
// Latency 1 cycle (push at edge N is poppable from N+1); in_ready drops only when full, independent of out_ready.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_instr,
    input  logic [WIDTH-1:0]         in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_instr,
    output logic [WIDTH-1:0]         out_pc,
    output logic [WIDTH-1:0]         out_pcplus4,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
    localparam logic [WIDTH-1:0] NOP      = WIDTH'(32'h0000_0013);

    logic [WIDTH-1:0] instr_mem_q [DEPTH];
    logic [WIDTH-1:0] pc_mem_q    [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic push;
    logic pop;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    always_comb begin
        push     = in_valid & in_ready;
        pop      = out_valid & out_ready;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; stale slots are hidden by count.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            instr_mem_q[wr_ptr_q] <= in_instr;
            pc_mem_q[wr_ptr_q]    <= in_pc;
        end
    end

    assign out_instr   = out_valid ? instr_mem_q[rd_ptr_q] : NOP;
    assign out_pc      = out_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign out_pcplus4 = out_valid ? (pc_mem_q[rd_ptr_q] + WIDTH'(4)) : '0;

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch queue between instruction memory and the decode stage (register file, control unit, sign extend).
- Buffers fetched instructions with their PC so that decode stalls do not stall instruction memory reads.
- Presents the head entry (instr, PC, PC+4) to decode with valid/ready handshakes on both sides.
- A redirect flush (taken branch/jump) drops all queued entries.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- WIDTH, 32, instruction and PC width in bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries (branch/jump redirect).
- in_valid  in  1  fetch side presents an instruction.
- in_ready  out  1  queue can accept an entry this cycle.
- in_instr  in  WIDTH  fetched instruction word.
- in_pc  in  WIDTH  address of in_instr.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode consumes the head this cycle.
- out_instr  out  WIDTH  head instruction.
- out_pc  out  WIDTH  head PC.
- out_pcplus4  out  WIDTH  head PC + 4.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high.
- Storage and pointers: circular buffer of DEPTH entries {instr, pc}. Read and write pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
- Transfer rules: push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It does not depend on out_ready, so there is no push-while-full even when a pop occurs in the same cycle.
- out_valid = (count != 0).
- Output path: head entry read combinationally from storage; there is no input-to-output bypass.
- Latency: an entry pushed at edge N is visible at the outputs after edge N (first cycle it can be popped is N+1). Minimum latency is 1 cycle.
- Count update on the clock edge:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
- Flush has priority over push and pop. On the edge where flush=1:
  - count=0, both pointers=0.
  - A simultaneous push is discarded and a simultaneous pop is ignored.
  - The cycle after a flush, out_valid=0 and in_ready=1.
- When empty: out_instr=32'h00000013 (NOP, addi x0,x0,0), out_pc=0, out_pcplus4=0. Decode therefore sees a harmless instruction on bubbles.
- out_pcplus4 = out_pc + 4, modulo 2^WIDTH. 32'hFFFFFFFC gives 0; the carry is dropped.
- Reset (rst=1 at an edge): same effect as flush. Outputs after reset: in_ready=1, out_valid=0, count=0, out_instr=NOP, out_pc=0, out_pcplus4=0.
- Reset mid-operation discards all entries. rst has priority over flush and handshakes.
- Storage array contents are not reset; they are masked by count.
- Order: strict FIFO, entries leave in push order.
- No state machine beyond the pointers and count. Full is count==DEPTH; empty is count==0.

Test Plan:
1. Reset and empty: rst=1 for 2 cycles then 0, in_valid=0 -> count=0, out_valid=0, in_ready=1, out_instr=32'h00000013, out_pc=0.
2. Fill and order: push pc 0x0,0x4,0x8,0xC (instr 0x00500093, 0x00100113, 0x002081B3, 0xFE000EE3) with out_ready=0 -> count=4, in_ready=0. A 5th push with in_valid=1 is not accepted. Then out_ready=1 -> the four instrs emerge in order over 4 cycles, out_pcplus4 = 0x4, 0x8, 0xC, 0x10.
3. Simultaneous push/pop: hold count=2, push and pop every cycle for 10 cycles with pc 0x100 upward -> count stays 2 and out_pc follows push order with 2-entry lag. Run long enough that the pointers wrap past DEPTH-1.
4. Flush priority: count=3, assert flush with in_valid=1 (pc 0x200) and out_ready=1 -> next cycle count=0, out_valid=0, and pc 0x200 is absent. A push the following cycle appears with count=1.
5. PC wrap: push pc=32'hFFFFFFFC -> out_pcplus4=0.
6. Reset mid-operation: count=3, assert rst together with a push -> next cycle count=0, out_valid=0, in_ready=1. Normal pushes resume after rst deasserts.
